// File: rtl/wired_pkg.sv
// Shared backend pipeline types and the CDB requester map.
// The CDB arbiter's optional starvation guard is enabled with WIRED_CDB_STARVE_GUARD_EN.
package wired_pkg;

   typedef struct packed {
      logic [7:0]  rob_tag;
      logic [31:0] data;
      logic        exc;
   } pipeline_cdb_t;

   localparam int unsigned CDB_REQ_LSU  = 32'd0;
   localparam int unsigned CDB_REQ_MDU  = 32'd1;
   localparam int unsigned CDB_REQ_ALU0 = 32'd2;
   localparam int unsigned CDB_REQ_ALU1 = 32'd3;
   localparam int unsigned CDB_LANES    = 32'd2;
   localparam int unsigned CDB_WAIT_W   = 32'd8;

endpackage

// File: rtl/wired_cdb_pick2.sv
// Combinational first/second set-bit finder with a one-hot override for the first pick.
// The override must be a subset of req; when it is zero, plain lowest-index priority applies.
module wired_cdb_pick2 #(
   parameter int unsigned REQ_NUM = 32'd4
) (
   input  logic [REQ_NUM-1:0] req,
   input  logic [REQ_NUM-1:0] force_oh,
   output logic [REQ_NUM-1:0] first_oh,
   output logic [REQ_NUM-1:0] second_oh,
   output logic               second_valid
);

   localparam logic [REQ_NUM-1:0] ONE_C = {{(REQ_NUM-1){1'b0}}, 1'b1};

   function automatic logic [REQ_NUM-1:0] lowest_oh(input logic [REQ_NUM-1:0] v);
      return v & (~v + ONE_C);
   endfunction

   logic [REQ_NUM-1:0] remain_s;

   // Pick the first winner (override or priority), then the next among the rest.
   always_comb begin
      first_oh     = {REQ_NUM{1'b0}};
      remain_s     = {REQ_NUM{1'b0}};
      second_oh    = {REQ_NUM{1'b0}};
      second_valid = 1'b0;
      if (|force_oh) begin
         first_oh = force_oh;
      end else begin
         first_oh = lowest_oh(req);
      end
      remain_s     = req & ~first_oh;
      second_oh    = lowest_oh(remain_s);
      second_valid = |remain_s;
   end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Two-lane CDB write-back arbiter: fixed priority, registered lanes, 1-cycle latency.
// Define WIRED_CDB_STARVE_GUARD_EN to compile in per-requester starvation promotion.
module wired_cdb_arbiter
   import wired_pkg::*;
#(
   parameter int unsigned REQ_NUM      = 32'd4,
   parameter int unsigned STARVE_LIMIT = 32'd8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  pipeline_cdb_t        req_payload_i [REQ_NUM],
   input  logic [REQ_NUM-1:0]   req_valid_i,
   output logic [REQ_NUM-1:0]   req_ready_o,
   input  logic                 flush_i,
   output pipeline_cdb_t        cdb_o [CDB_LANES],
   output logic [CDB_LANES-1:0] cdb_valid_o
);

   logic [REQ_NUM-1:0]   req_vec_s;
   logic [REQ_NUM-1:0]   force_s;
   logic [REQ_NUM-1:0]   first_oh_s;
   logic [REQ_NUM-1:0]   second_oh_s;
   logic                 second_valid_s;
   pipeline_cdb_t        lane0_s;
   pipeline_cdb_t        lane1_s;
   pipeline_cdb_t        cdb_r [CDB_LANES];
   logic [CDB_LANES-1:0] cdb_valid_r;

   // Reset and flush both mask every request so nothing is granted.
   always_comb begin
      req_vec_s = {REQ_NUM{1'b0}};
      if (!rst_n || flush_i) begin
         req_vec_s = {REQ_NUM{1'b0}};
      end else begin
         req_vec_s = req_valid_i;
      end
   end

`ifdef WIRED_CDB_STARVE_GUARD_EN
   localparam logic [CDB_WAIT_W-1:0] LIMIT_C = CDB_WAIT_W'(STARVE_LIMIT);

   logic [CDB_WAIT_W-1:0] wait_cnt_r [REQ_NUM];
   logic                  found_s;

   // Promote the lowest-index requester whose wait counter is saturated.
   always_comb begin
      force_s = {REQ_NUM{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (!found_s && req_vec_s[i] && (wait_cnt_r[i] == LIMIT_C)) begin
            force_s[i] = 1'b1;
            found_s    = 1'b1;
         end else begin
            force_s[i] = 1'b0;
         end
      end
   end

   // Wait counters: count stalled cycles, saturate at the limit, clear on grant/idle/flush.
   always_ff @(posedge clk) begin
      for (int i = 0; i < REQ_NUM; i++) begin
         if (!rst_n || flush_i) begin
            wait_cnt_r[i] <= {CDB_WAIT_W{1'b0}};
         end else if (req_ready_o[i] || !req_valid_i[i]) begin
            wait_cnt_r[i] <= {CDB_WAIT_W{1'b0}};
         end else if (wait_cnt_r[i] != LIMIT_C) begin
            wait_cnt_r[i] <= wait_cnt_r[i] + {{(CDB_WAIT_W-1){1'b0}}, 1'b1};
         end else begin
            wait_cnt_r[i] <= wait_cnt_r[i];
         end
      end
   end
`else
   assign force_s = {REQ_NUM{1'b0}};
`endif

   wired_cdb_pick2 #(
      .REQ_NUM (REQ_NUM)
   ) u_pick2 (
      .req          (req_vec_s),
      .force_oh     (force_s),
      .first_oh     (first_oh_s),
      .second_oh    (second_oh_s),
      .second_valid (second_valid_s)
   );

   assign req_ready_o = first_oh_s | second_oh_s;

   // One-hot payload muxes for the two lanes.
   always_comb begin
      lane0_s = '0;
      lane1_s = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (first_oh_s[i]) begin
            lane0_s = lane0_s | req_payload_i[i];
         end else begin
            lane0_s = lane0_s;
         end
         if (second_oh_s[i]) begin
            lane1_s = lane1_s | req_payload_i[i];
         end else begin
            lane1_s = lane1_s;
         end
      end
   end

   // CDB output registers; payload holds while its lane is idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cdb_valid_r <= {CDB_LANES{1'b0}};
         cdb_r[0]    <= '0;
         cdb_r[1]    <= '0;
      end else begin
         cdb_valid_r <= {second_valid_s, |first_oh_s};
         if (|first_oh_s) begin
            cdb_r[0] <= lane0_s;
         end
         if (second_valid_s) begin
            cdb_r[1] <= lane1_s;
         end
      end
   end

   assign cdb_o       = cdb_r;
   assign cdb_valid_o = cdb_valid_r;

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Directed self-checking bench for wired_cdb_arbiter (default build or WIRED_CDB_STARVE_GUARD_EN).
// Inputs change 1 time unit after posedge; outputs are checked after settling.
module tb_wired_cdb_arbiter;
   import wired_pkg::*;

   logic          clk;
   logic          rst_n;
   pipeline_cdb_t req_payload [4];
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic          flush;
   pipeline_cdb_t cdb [2];
   logic [1:0]    cdb_valid;

   int n_cmp  = 0;
   int n_fail = 0;

   pipeline_cdb_t p [4];

   wired_cdb_arbiter #(
      .REQ_NUM      (32'd4),
      .STARVE_LIMIT (32'd8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_payload_i (req_payload),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .flush_i       (flush),
      .cdb_o         (cdb),
      .cdb_valid_o   (cdb_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic pipeline_cdb_t mk(input logic [7:0] tag, input logic [31:0] d);
      pipeline_cdb_t r;
      r.rob_tag = tag;
      r.data    = d;
      r.exc     = 1'b0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      p[0] = mk(8'h11, 32'hD000_0000);
      p[1] = mk(8'h22, 32'hD111_1111);
      p[2] = mk(8'h33, 32'hD222_2222);
      p[3] = mk(8'hA5, 32'h0000_00A5);
      for (int i = 0; i < 4; i++) req_payload[i] = p[i];
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = 4'b1111;

      // Reset held for 3 cycles with all requests pending.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_ready", 64'(req_ready), 64'(4'b0000));
         chk("rst_valid", 64'(cdb_valid), 64'(2'b00));
         chk("rst_lane0", 64'(cdb[0]), 64'(0));
      end

      // Fixed priority: LSU+MDU win, results appear one cycle later.
      rst_n = 1'b1;
      #1;
      chk("pri_ready0", 64'(req_ready), 64'(4'b0011));
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("pri_valid", 64'(cdb_valid), 64'(2'b11));
         chk("pri_lane0", 64'(cdb[0]), 64'(p[0]));
         chk("pri_lane1", 64'(cdb[1]), 64'(p[1]));
         chk("pri_ready", 64'(req_ready), 64'(4'b0011));
      end

      // Idle cycle drains lanes (and clears wait counters when guarded).
      req_valid = 4'b0000;
      #1;
      chk("idle_ready", 64'(req_ready), 64'(4'b0000));
      tick();
      chk("idle_valid", 64'(cdb_valid), 64'(2'b00));

      // Single request from ALU1.
      req_valid = 4'b1000;
      #1;
      chk("single_ready", 64'(req_ready), 64'(4'b1000));
      tick();
      chk("single_valid", 64'(cdb_valid), 64'(2'b01));
      chk("single_lane0", 64'(cdb[0]), 64'(p[3]));

      // Flush: already-registered result stays visible, next load is empty.
      req_valid = 4'b0110;
      flush     = 1'b1;
      #1;
      chk("flush_ready", 64'(req_ready), 64'(4'b0000));
      chk("flush_cur_valid", 64'(cdb_valid), 64'(2'b01));
      tick();
      chk("flush_valid", 64'(cdb_valid), 64'(2'b00));
      flush = 1'b0;
      #1;
      chk("post_flush_ready", 64'(req_ready), 64'(4'b0110));
      tick();
      chk("post_flush_valid", 64'(cdb_valid), 64'(2'b11));
      chk("post_flush_lane0", 64'(cdb[0]), 64'(p[1]));
      chk("post_flush_lane1", 64'(cdb[1]), 64'(p[2]));

      // Back-to-back MDU results, new payload each cycle.
      req_valid = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         req_payload[1] = mk(8'h40 + 8'(k), 32'h0000_0B00 + 32'(k));
         #1;
         chk("b2b_ready", 64'(req_ready), 64'(4'b0010));
         tick();
         chk("b2b_valid", 64'(cdb_valid), 64'(2'b01));
         chk("b2b_lane0", 64'(cdb[0]), 64'(mk(8'h40 + 8'(k), 32'h0000_0B00 + 32'(k))));
      end
      req_payload[1] = p[1];
      req_valid      = 4'b0000;
      tick();
      chk("b2b_drain", 64'(cdb_valid), 64'(2'b00));

      // Reset mid-operation discards the pending load.
      req_valid = 4'b1111;
      #1;
      chk("mid_ready", 64'(req_ready), 64'(4'b0011));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'(4'b0000));
      tick();
      chk("mid_rst_valid", 64'(cdb_valid), 64'(2'b00));
      chk("mid_rst_lane1", 64'(cdb[1]), 64'(0));
      rst_n = 1'b1;
      #1;

`ifdef WIRED_CDB_STARVE_GUARD_EN
      // Steady 1111: ALU0 promoted at cycle 8, ALU1 at cycle 9, then normal priority.
      for (int c = 0; c <= 10; c++) begin
         if (c == 8) begin
            chk("starve_ready8", 64'(req_ready), 64'(4'b0101));
            tick();
            chk("starve_lane0_8", 64'(cdb[0]), 64'(p[2]));
            chk("starve_lane1_8", 64'(cdb[1]), 64'(p[0]));
         end else if (c == 9) begin
            chk("starve_ready9", 64'(req_ready), 64'(4'b1001));
            tick();
            chk("starve_lane0_9", 64'(cdb[0]), 64'(p[3]));
            chk("starve_lane1_9", 64'(cdb[1]), 64'(p[0]));
         end else begin
            chk("starve_ready", 64'(req_ready), 64'(4'b0011));
            tick();
            chk("starve_lane0", 64'(cdb[0]), 64'(p[0]));
            chk("starve_lane1", 64'(cdb[1]), 64'(p[1]));
         end
         chk("starve_valid", 64'(cdb_valid), 64'(2'b11));
      end
`else
      // Without the guard, ALU0/ALU1 never win against steady LSU/MDU.
      for (int c = 0; c < 12; c++) begin
         chk("nostarve_ready", 64'(req_ready), 64'(4'b0011));
         tick();
         chk("nostarve_lane0", 64'(cdb[0]), 64'(p[0]));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
